// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer
//   Drives an external WIDTH-to-1 MUX as a parallel-to-serial converter.
//   A word is captured on i_load_data. The block then drives it onto
//   o_mux_in and steps o_sel through every index. The MUX output i_mux_f
//   comes back and is presented as a valid/ready serial stream with a
//   last-beat flag.
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_load_valid/i_load_data   word offer; o_load_ready = accept this cycle
//   o_mux_in, o_sel            MUX data and select drive
//   i_mux_f                    MUX output (combinational from o_mux_in/o_sel)
//   o_ser_valid/i_ser_ready    serial handshake; o_ser_bit = i_mux_f
//   o_ser_last                 final beat of the current word
//   o_busy                     word in flight
//   o_done                     one-cycle pulse after the last beat is accepted
module mux_scan_serializer #(
  parameter int WIDTH     = 16,
  parameter int SEL_W     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_load_data,
  output logic             o_load_ready,
  output logic [WIDTH-1:0] o_mux_in,
  output logic [SEL_W-1:0] o_sel,
  input  logic             i_mux_f,
  output logic             o_ser_valid,
  input  logic             i_ser_ready,
  output logic             o_ser_bit,
  output logic             o_ser_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(WIDTH-1) : '0;
  localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? '0 : SEL_W'(WIDTH-1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mux_in;
  logic [SEL_W-1:0] r_sel;
  logic             r_done;

  logic w_shift;
  logic w_last;
  logic w_beat_acc;
  logic w_last_acc;
  logic w_load_acc;

  assign w_shift    = (r_state == SHIFT);
  assign w_last     = w_shift && (r_sel == SEL_END);
  assign w_beat_acc = w_shift && i_ser_ready;
  assign w_last_acc = w_beat_acc && w_last;
  // The last accepted beat frees the capture register in the same cycle.
  // A new word can therefore follow with no idle bubble.
  assign w_load_acc = i_load_valid && o_load_ready;

  assign o_load_ready = !w_shift || w_last_acc;
  assign o_mux_in     = r_mux_in;
  assign o_sel        = r_sel;
  assign o_ser_valid  = w_shift;
  assign o_ser_bit    = i_mux_f;
  assign o_ser_last   = w_last;
  assign o_busy       = w_shift;
  assign o_done       = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_mux_in <= '0;
      r_sel    <= SEL_START;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load_acc) begin
            r_mux_in <= i_load_data;
            r_sel    <= SEL_START;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last_acc) begin
            r_done <= 1'b1;
            if (w_load_acc) begin
              r_mux_in <= i_load_data;
              r_sel    <= SEL_START;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_beat_acc) begin
            // The end index is never passed, so there is no wrap within a word.
            r_sel <= MSB_FIRST ? r_sel - SEL_W'(1) : r_sel + SEL_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
module tb_mux_scan_serializer;
  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             ser_ready = 1'b0;

  logic             load_ready0, load_ready1;
  logic [WIDTH-1:0] mux_in0, mux_in1;
  logic [SEL_W-1:0] sel0, sel1;
  logic             mux_f0, mux_f1;
  logic             ser_valid0, ser_valid1, ser_bit0, ser_bit1;
  logic             ser_last0, ser_last1, busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  // External 16:1 MUX
  assign mux_f0 = mux_in0[sel0];
  assign mux_f1 = mux_in1[sel1];

  mux_scan_serializer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_load_valid(load_valid), .i_load_data(load_data),
    .o_load_ready(load_ready0), .o_mux_in(mux_in0), .o_sel(sel0), .i_mux_f(mux_f0),
    .o_ser_valid(ser_valid0), .i_ser_ready(ser_ready), .o_ser_bit(ser_bit0),
    .o_ser_last(ser_last0), .o_busy(busy0), .o_done(done0));

  mux_scan_serializer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_load_valid(load_valid), .i_load_data(load_data),
    .o_load_ready(load_ready1), .o_mux_in(mux_in1), .o_sel(sel1), .i_mux_f(mux_f1),
    .o_ser_valid(ser_valid1), .i_ser_ready(ser_ready), .o_ser_bit(ser_bit1),
    .o_ser_last(ser_last1), .o_busy(busy1), .o_done(done1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a word in flight is described by its value and the
  // number of beats still owed. Beat k of the word is bit k (LSB first) or
  // bit WIDTH-1-k (MSB first).
  bit               mon_en   = 1'b0;
  int               m_rem    = 0;
  logic [WIDTH-1:0] m_word   = '0;
  bit               m_done   = 1'b0;
  bit               m_at_rst = 1'b1;
  int               m_pos;

  always @(negedge clk) if (mon_en) begin
    m_pos = WIDTH - m_rem;
    chk("valid0", 32'(ser_valid0), 32'(m_rem != 0));
    chk("valid1", 32'(ser_valid1), 32'(m_rem != 0));
    chk("busy0", 32'(busy0), 32'(m_rem != 0));
    chk("busy1", 32'(busy1), 32'(m_rem != 0));
    chk("ldrdy0", 32'(load_ready0), 32'((m_rem == 0) || (m_rem == 1 && ser_ready)));
    chk("ldrdy1", 32'(load_ready1), 32'((m_rem == 0) || (m_rem == 1 && ser_ready)));
    chk("done0", 32'(done0), 32'(m_done));
    chk("done1", 32'(done1), 32'(m_done));
    chk("muxin0", 32'(mux_in0), 32'(m_word));
    chk("muxin1", 32'(mux_in1), 32'(m_word));
    if (m_rem != 0) begin
      chk("sel0", 32'(sel0), 32'(m_pos));
      chk("sel1", 32'(sel1), 32'(WIDTH - 1 - m_pos));
      chk("bit0", 32'(ser_bit0), 32'(m_word[m_pos]));
      chk("bit1", 32'(ser_bit1), 32'(m_word[WIDTH-1-m_pos]));
      chk("last0", 32'(ser_last0), 32'(m_rem == 1));
      chk("last1", 32'(ser_last1), 32'(m_rem == 1));
    end else if (m_at_rst) begin
      chk("rstsel0", 32'(sel0), 32'(0));
      chk("rstsel1", 32'(sel1), 32'(WIDTH - 1));
    end
    // advance the model by the edge that is coming
    m_done = 1'b0;
    if (rst) begin
      m_rem = 0; m_word = '0; m_at_rst = 1'b1;
    end else begin
      if (m_rem != 0 && ser_ready) begin
        if (m_rem == 1) m_done = 1'b1;
        m_rem--;
      end
      if (m_rem == 0 && load_valid) begin
        m_word = load_data; m_rem = WIDTH; m_at_rst = 1'b0;
      end
    end
  end

  task automatic drive(input logic lv, input logic [WIDTH-1:0] d, input logic rdy,
                       input logic rs);
    load_valid = lv; load_data = d; ser_ready = rdy; rst = rs;
    @(posedge clk); #1;
  endtask

  logic [WIDTH-1:0] w_aa56 = 16'haa56;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b1);
    mon_en = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("rst_muxin", 32'(mux_in0), 32'(0));
    chk("rst_sel1", 32'(sel1), 32'(15));
    chk("rst_ready", 32'(load_ready0), 32'(1));

    // T1/T2: one word with ser_ready held high, then idle
    drive(1'b1, 16'haa56, 1'b1, 1'b0);
    for (int i = 0; i < WIDTH + 2; i++) drive(1'b0, '0, 1'b1, 1'b0);

    // T3/T5: stall at sel=5, offer a word mid-transfer
    drive(1'b1, 16'haa56, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_sel", 32'(sel0), 32'(5));
      chk("hold_bit", 32'(ser_bit0), 32'(w_aa56[5]));
      drive(1'b1, 16'h1234, 1'b0, 1'b0);
      chk("t5_muxin", 32'(mux_in0), 32'(16'haa56));
    end
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    chk("t5_muxin2", 32'(mux_in0), 32'(16'haa56));
    for (int i = 0; i < WIDTH; i++) drive(1'b0, '0, 1'b1, 1'b0);

    // T4: back-to-back words, load offered only on the last beat
    drive(1'b1, 16'hffff, 1'b1, 1'b0);
    for (int i = 0; i < WIDTH - 1; i++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 16'h0001, 1'b1, 1'b0);
    chk("t4_b2b_valid", 32'(ser_valid0), 32'(1));
    chk("t4_b2b_word", 32'(mux_in0), 32'(16'h0001));
    for (int i = 0; i < WIDTH + 1; i++) drive(1'b0, '0, 1'b1, 1'b0);

    // T6: reset at beat 7 aborts the word
    drive(1'b1, 16'haa56, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("t6_sel0", 32'(sel0), 32'(0));
    chk("t6_muxin", 32'(mux_in0), 32'(0));
    chk("t6_valid", 32'(ser_valid0), 32'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t6_nodone", 32'(done0), 32'(0));

    // random traffic
    for (int i = 0; i < 4000; i++)
      drive(1'($urandom_range(0, 3) == 0), WIDTH'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));

    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
